// File: rtl/clk_divide_prog.sv
// Programmable clock divider: clk_out period N = div_active, low floor(N/2) cycles, then high.
// Define CLK_DIVIDE_PROG_TICK_EN to build the tick pulse logic; otherwise tick is tied low.
module clk_divide_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             cfg_err
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q, clk_out_d;
  logic             cfg_err_q, cfg_err_d;

  logic             legal_load;
  logic             wrap;
  logic [WIDTH-1:0] half;

  assign legal_load = div_load && (div_val >= WIDTH'(2));
  assign wrap       = en && (cnt_q == div_active_q - WIDTH'(1));
  assign half       = div_active_q >> 1;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    cnt_d        = cnt_q;
    div_active_d = div_active_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    clk_out_d    = clk_out_q;
    cfg_err_d    = div_load && !legal_load;

    if (wrap) begin
      cnt_d      = '0;
      pend_vld_d = 1'b0;
      // A legal load landing on the wrap beats the older pending value.
      if (legal_load) begin
        div_active_d = div_val;
      end else if (pend_vld_q) begin
        div_active_d = pend_q;
      end
    end else begin
      if (en) begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      if (legal_load) begin
        pend_d     = div_val;
        pend_vld_d = 1'b1;
      end
    end

    // Wrap yields cnt_d = 0 < half, so the new period always starts low.
    if (en) begin
      clk_out_d = (cnt_d >= half);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q        <= '0;
      div_active_q <= WIDTH'(DEFAULT_DIV);
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      clk_out_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_active_q <= div_active_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      clk_out_q    <= clk_out_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

`ifdef CLK_DIVIDE_PROG_TICK_EN
  logic tick_q, tick_d;

  always_comb begin
    tick_d = en && !wrap && (cnt_d == half);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

  assign clk_out    = clk_out_q;
  assign div_active = div_active_q;
  assign cfg_err    = cfg_err_q;

endmodule
